// File: rtl/genius_pkg.sv
// Shared definitions for the parametrised memory game: FSM state codes,
// LFSR geometry and small helper functions.
package genius_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    GERA        = 4'd2,
    MOSTRA      = 4'd3,
    PAUSA       = 4'd4,
    ESPERA      = 4'd5,
    COMPARA     = 4'd7,
    PROXIMA     = 4'd8,
    FIM_ACERTO  = 4'd10,
    FIM_ERRO    = 4'd14,
    FIM_TIMEOUT = 4'd15
  } estado_t;

  localparam int LFSR_W = 8;
  // Fibonacci taps for x^8+x^6+x^5+x^4+1, expressed as bit positions 7,5,4,3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/gerador_lfsr.sv
// 8-bit Fibonacci LFSR that steps only when enabled and reloads its seed on reset.
module gerador_lfsr
  import genius_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEMENTE = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) q <= SEMENTE;
    else if (enable) q <= lfsr_next(q);
  end

endmodule

// File: rtl/jogo_memoria_param.sv
// Simon-style memory game: grows a pseudo-random sequence one symbol per round,
// plays it on one-hot LEDs and checks the player's presses against it.
module jogo_memoria_param
  import genius_pkg::*;
#(
  parameter int          N_BOTOES    = 4,
  parameter int          MAX_RODADAS = 16,
  parameter int          T_MOSTRA    = 1000,
  parameter int          T_PAUSA     = 250,
  parameter int          T_TIMEOUT   = 3000,
  parameter logic [7:0]  SEMENTE     = 8'hA5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                dificuldade,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic [3:0]          estado,
  output logic [7:0]          pontuacao,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout
);

  localparam int SYM_W   = $clog2(N_BOTOES);
  localparam int RW      = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;
  localparam int TM_FAST = (T_MOSTRA / 2 > 0) ? T_MOSTRA / 2 : 1;
  localparam int TP_FAST = (T_PAUSA / 2 > 0) ? T_PAUSA / 2 : 1;
  localparam int T_MAX   = (T_MOSTRA > T_PAUSA) ? T_MOSTRA : T_PAUSA;
  localparam int TW      = $clog2(T_MAX + 1);
  localparam int TOW     = $clog2(T_TIMEOUT + 1);

  estado_t             state, state_n;
  logic [RW-1:0]       rodada, rodada_n, addr, addr_n;
  logic [TW-1:0]       tmr, tmr_n, tm_last, tp_last;
  logic [TOW-1:0]      tcnt, tcnt_n;
  logic [7:0]          pont_n;
  logic                dif_q, dif_n, prev_or, press;
  logic [N_BOTOES-1:0] padrao, padrao_n;
  logic [SYM_W-1:0]    mem [MAX_RODADAS];
  logic [SYM_W-1:0]    new_sym, sym_rd;
  logic [7:0]          lfsr_q, exp_full, led_full;

  gerador_lfsr #(.SEMENTE(SEMENTE)) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (state == GERA),
    .q      (lfsr_q)
  );

  // Memory takes the value the LFSR steps to in this same GERA cycle.
  assign new_sym = SYM_W'(lfsr_next(lfsr_q) % N_BOTOES);
  assign tm_last = dif_q ? TW'(TM_FAST - 1) : TW'(T_MOSTRA - 1);
  assign tp_last = dif_q ? TW'(TP_FAST - 1) : TW'(T_PAUSA - 1);
  // botoes are level inputs; a press is only the cycle OR(botoes) rises 0->1.
  assign press    = (|botoes) & ~prev_or;
  assign exp_full = onehot(3'(mem[addr]));
  assign estado   = state;

  always_ff @(posedge clock) begin
    if (state == GERA) mem[rodada] <= new_sym;
  end

  always_comb begin
    state_n  = state;
    rodada_n = rodada;
    addr_n   = addr;
    tmr_n    = tmr;
    tcnt_n   = tcnt;
    pont_n   = pontuacao;
    dif_n    = dif_q;
    padrao_n = padrao;
    case (state)
      INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (jogar) begin
          dif_n    = dificuldade;
          pont_n   = '0;
          rodada_n = '0;
          addr_n   = '0;
          state_n  = GERA;
        end
      end
      GERA: begin
        addr_n  = '0;
        tmr_n   = '0;
        state_n = MOSTRA;
      end
      MOSTRA: begin
        if (tmr == tm_last) begin
          tmr_n   = '0;
          state_n = PAUSA;
        end else tmr_n = tmr + 1'b1;
      end
      PAUSA: begin
        if (tmr == tp_last) begin
          tmr_n = '0;
          if (addr < rodada) begin
            addr_n  = addr + 1'b1;
            state_n = MOSTRA;
          end else begin
            addr_n  = '0;
            tcnt_n  = '0;
            state_n = ESPERA;
          end
        end else tmr_n = tmr + 1'b1;
      end
      ESPERA: begin
        tcnt_n = tcnt + 1'b1;
        if (press) begin
          padrao_n = botoes;
          state_n  = COMPARA;
        end else if (tcnt == TOW'(T_TIMEOUT - 1)) begin
          state_n = FIM_TIMEOUT;
        end
      end
      COMPARA: begin
        if (padrao != exp_full[N_BOTOES-1:0]) begin
          state_n = FIM_ERRO;
        end else if (addr < rodada) begin
          addr_n  = addr + 1'b1;
          tcnt_n  = '0;
          state_n = ESPERA;
        end else begin
          state_n = PROXIMA;
        end
      end
      PROXIMA: begin
        pont_n = pontuacao + 8'd1;
        if ({1'b0, pontuacao} + 9'd1 == 9'(MAX_RODADAS)) begin
          state_n = FIM_ACERTO;
        end else begin
          rodada_n = rodada + 1'b1;
          state_n  = GERA;
        end
      end
      default: state_n = INICIAL;
    endcase
  end

  // Bypass the memory when the symbol being shown is the one written this cycle.
  always_comb begin
    sym_rd   = mem[addr_n];
    if (state == GERA && rodada == addr_n) sym_rd = new_sym;
    led_full = onehot(3'(sym_rd));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INICIAL;
      rodada    <= '0;
      addr      <= '0;
      tmr       <= '0;
      tcnt      <= '0;
      pontuacao <= '0;
      dif_q     <= 1'b0;
      prev_or   <= 1'b0;
      padrao    <= '0;
      leds      <= '0;
      pronto    <= 1'b0;
      ganhou    <= 1'b0;
      perdeu    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      rodada    <= rodada_n;
      addr      <= addr_n;
      tmr       <= tmr_n;
      tcnt      <= tcnt_n;
      pontuacao <= pont_n;
      dif_q     <= dif_n;
      prev_or   <= |botoes;
      padrao    <= padrao_n;
      leds      <= (state_n == MOSTRA) ? led_full[N_BOTOES-1:0] : '0;
      pronto    <= (state_n == FIM_ACERTO) || (state_n == FIM_ERRO) || (state_n == FIM_TIMEOUT);
      ganhou    <= (state_n == FIM_ACERTO);
      perdeu    <= (state_n == FIM_ERRO) || (state_n == FIM_TIMEOUT);
      timeout   <= (state_n == FIM_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Bench for jogo_memoria_param: directed games with a scoreboard of expected
// LED pulses, pauses, scores and end-state records checked by a monitor.
module tb_jogo_memoria_param;

  logic       clock = 1'b0;
  logic       reset, jogar, dificuldade;
  logic [3:0] botoes, leds, estado;
  logic [7:0] pontuacao;
  logic       pronto, ganhou, perdeu, timeout;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] pulse_q[$];  // {leds, length}
  logic [7:0]  pause_q[$];
  logic [7:0]  score_q[$];
  logic [15:0] end_q[$];    // {estado, pontuacao, pronto, ganhou, perdeu, timeout}

  always #5 clock = ~clock;

  jogo_memoria_param #(
    .N_BOTOES(4), .MAX_RODADAS(3), .T_MOSTRA(4), .T_PAUSA(2),
    .T_TIMEOUT(20), .SEMENTE(8'hA5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .jogar       (jogar),
    .dificuldade (dificuldade),
    .botoes      (botoes),
    .leds        (leds),
    .estado      (estado),
    .pontuacao   (pontuacao),
    .pronto      (pronto),
    .ganhou      (ganhou),
    .perdeu      (perdeu),
    .timeout     (timeout)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_estado"}, 32'(estado), 32'd0);
    check({tag, "_leds"}, 32'(leds), 32'd0);
    check({tag, "_pontuacao"}, 32'(pontuacao), 32'd0);
    check({tag, "_pronto"}, 32'(pronto), 32'd0);
    check({tag, "_ganhou"}, 32'(ganhou), 32'd0);
    check({tag, "_perdeu"}, 32'(perdeu), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (estado !== st && n < budget);
    if (estado !== st) begin
      compared++;
      mismatched++;
      $display("FAIL wait_state: estado=%0d, required %0d within %0d cycles", estado, st, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start_game(input logic d);
    @(negedge clock);
    dificuldade = d;
    jogar       = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
  endtask

  task automatic press(input logic [3:0] p);
    wait_state(4'd5, 200);
    botoes = p;
    @(negedge clock);
    botoes = '0;
  endtask

  task automatic push_play(input logic [3:0] p, input int on_len, input int off_len);
    pulse_q.push_back({p, 8'(on_len)});
    pause_q.push_back(8'(off_len));
  endtask

  // Monitor: turns DUT activity into records and checks them against the queues.
  logic [3:0] m_leds = '0;
  logic [3:0] m_est  = '0;
  logic [7:0] m_pont = '0;
  int         m_len  = 0;
  int         m_plen = 0;

  always @(negedge clock) begin
    logic [15:0] exp16;
    logic [11:0] exp12;
    logic [7:0]  exp8;
    if (reset) begin
      m_leds = '0;
      m_len  = 0;
      m_plen = 0;
      m_est  = estado;
      m_pont = pontuacao;
    end else begin
      if (leds != 0) begin
        m_len = (m_leds == 0) ? 1 : m_len + 1;
      end else if (m_leds != 0) begin
        compared++;
        if (pulse_q.size() == 0) begin
          mismatched++;
          $display("FAIL pulse: got leds=%b len=%0d, none expected", m_leds, m_len);
        end else begin
          exp12 = pulse_q.pop_front();
          if ({m_leds, 8'(m_len)} !== exp12) begin
            mismatched++;
            $display("FAIL pulse: got leds=%b len=%0d, expected leds=%b len=%0d",
                     m_leds, m_len, exp12[11:8], exp12[7:0]);
          end
        end
      end
      m_leds = leds;

      if (estado == 4'd4) m_plen++;
      else if (m_plen != 0) begin
        compared++;
        if (pause_q.size() == 0) begin
          mismatched++;
          $display("FAIL pause: got len=%0d, none expected", m_plen);
        end else begin
          exp8 = pause_q.pop_front();
          if (8'(m_plen) !== exp8) begin
            mismatched++;
            $display("FAIL pause: got len=%0d expected %0d", m_plen, exp8);
          end
        end
        m_plen = 0;
      end

      if (pontuacao != m_pont && pontuacao != 0) begin
        compared++;
        if (score_q.size() == 0) begin
          mismatched++;
          $display("FAIL score: got %0d, none expected", pontuacao);
        end else begin
          exp8 = score_q.pop_front();
          if (pontuacao !== exp8) begin
            mismatched++;
            $display("FAIL score: got %0d expected %0d", pontuacao, exp8);
          end
        end
      end
      m_pont = pontuacao;

      if ((estado == 4'd10 || estado == 4'd14 || estado == 4'd15) && estado != m_est) begin
        compared++;
        if (end_q.size() == 0) begin
          mismatched++;
          $display("FAIL end_state: got estado=%0d, none expected", estado);
        end else begin
          exp16 = end_q.pop_front();
          if ({estado, pontuacao, pronto, ganhou, perdeu, timeout} !== exp16) begin
            mismatched++;
            $display("FAIL end_state: got %h expected %h",
                     {estado, pontuacao, pronto, ganhou, perdeu, timeout}, exp16);
          end
        end
      end
      m_est = estado;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int n;
    reset = 1'b1; jogar = 1'b0; dificuldade = 1'b0; botoes = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Full win: symbols 2,1,2 from LFSR 4A, 95, 2A.
    push_play(4'b0100, 4, 2);
    push_play(4'b0100, 4, 2); push_play(4'b0010, 4, 2);
    push_play(4'b0100, 4, 2); push_play(4'b0010, 4, 2); push_play(4'b0100, 4, 2);
    score_q.push_back(8'd1); score_q.push_back(8'd2); score_q.push_back(8'd3);
    end_q.push_back({4'd10, 8'd3, 4'b1100});
    start_game(1'b0);
    press(4'b0100);
    press(4'b0100); press(4'b0010);
    press(4'b0100); press(4'b0010); press(4'b0100);
    wait_state(4'd10, 100);

    // Wrong press in round 2.
    do_reset();
    push_play(4'b0100, 4, 2);
    push_play(4'b0100, 4, 2); push_play(4'b0010, 4, 2);
    score_q.push_back(8'd1);
    end_q.push_back({4'd14, 8'd1, 4'b1010});
    start_game(1'b0);
    press(4'b0100);
    press(4'b0100); press(4'b1000);
    wait_state(4'd14, 100);

    // Press on the last allowed ESPERA cycle, then a real timeout.
    do_reset();
    push_play(4'b0100, 4, 2);
    push_play(4'b0100, 4, 2); push_play(4'b0010, 4, 2);
    score_q.push_back(8'd1);
    end_q.push_back({4'd15, 8'd1, 4'b1011});
    start_game(1'b0);
    wait_state(4'd5, 100);
    repeat (19) @(negedge clock);
    botoes = 4'b0100;
    @(negedge clock);
    botoes = '0;
    wait_state(4'd5, 200);
    n = 1;
    while (estado == 4'd5 && n < 100) begin
      @(negedge clock);
      if (estado == 4'd5) n++;
    end
    check("espera_cycles", 32'(n), 32'd20);

    // Fast mode, multi-bit press.
    do_reset();
    push_play(4'b0100, 2, 1);
    end_q.push_back({4'd14, 8'd0, 4'b1010});
    start_game(1'b1);
    press(4'b0110);
    wait_state(4'd14, 100);

    // Restart without reset advances the LFSR to 95; reset mid-playback reseeds.
    start_game(1'b0);
    n = 0;
    while (leds == 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("leds_no_reseed", 32'(leds), 32'b0010);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    push_play(4'b0100, 4, 2);
    start_game(1'b0);
    wait_state(4'd5, 100);

    repeat (5) @(negedge clock);
    check("pulse_q_left", 32'(pulse_q.size()), 32'd0);
    check("pause_q_left", 32'(pause_q.size()), 32'd0);
    check("score_q_left", 32'(score_q.size()), 32'd0);
    check("end_q_left", 32'(end_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
